// File: rtl/ir_bus_responder.sv
// Instruction-fetch bus responder: word-addressed instruction RAM with a
// preload port, a fixed-latency delay line, an in-order response FIFO and a
// credit counter bounding accepted-but-not-returned requests.
module ir_bus_responder #(
   parameter int data_width      = 32,
   parameter int addr_width      = 32,
   parameter int mem_words       = 256,
   parameter int latency         = 2,
   parameter int max_outstanding = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  bus_ir_addr_valid,
   output logic                  bus_ir_addr_ready,
   input  logic [addr_width-1:0] bus_ir_addr,
   output logic                  bus_ir_data_valid,
   input  logic                  bus_ir_data_ready,
   output logic [data_width-1:0] bus_ir_data,
   input  logic                  mem_wr_en,
   input  logic [addr_width-1:0] mem_wr_addr,
   input  logic [data_width-1:0] mem_wr_data
);

   localparam int IDX_W = $clog2(mem_words);
   localparam int OUT_W = $clog2(max_outstanding + 1);
   localparam int PTR_W = (max_outstanding > 1) ? $clog2(max_outstanding) : 1;
   localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(max_outstanding);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(max_outstanding - 1);

   logic [data_width-1:0] r_mem  [mem_words];
   logic [data_width-1:0] r_fifo [max_outstanding];
   logic [OUT_W-1:0]      r_outstanding;
   logic [OUT_W-1:0]      r_count;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;

   logic                  w_accept;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_fifo_full;
   logic [IDX_W-1:0]      w_acc_idx;
   logic [IDX_W-1:0]      w_wr_idx;
   logic [IDX_W-1:0]      w_push_idx;
   logic                  w_unused_addr;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // Byte addresses map to words; low two bits and bits above the RAM depth alias.
   assign w_acc_idx     = bus_ir_addr[IDX_W+1:2];
   assign w_wr_idx      = mem_wr_addr[IDX_W+1:2];
   assign w_unused_addr = ^{bus_ir_addr, mem_wr_addr};

   // Ready comes from the credit register only, so it never follows data_ready combinationally.
   assign bus_ir_addr_ready = (r_outstanding < MAX_OUT);
   assign w_accept          = bus_ir_addr_valid && bus_ir_addr_ready;
   assign bus_ir_data_valid = (r_count != '0);
   assign bus_ir_data       = r_fifo[r_rd_ptr];
   assign w_pop             = bus_ir_data_valid && bus_ir_data_ready;
   assign w_fifo_full       = (r_count == MAX_OUT);

   // Credit counter: one credit per accept, returned on each data handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_outstanding <= '0;
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   generate
      if (latency == 1) begin : g_no_dl
         assign w_push     = w_accept;
         assign w_push_idx = w_acc_idx;
      end else begin : g_dl
         logic [latency-2:0] r_dl_vld;
         logic [IDX_W-1:0]   r_dl_idx [latency-1];

         // Valid bits of the delay line; cleared on reset to drop in-flight requests.
         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               r_dl_vld <= '0;
            end else begin
               r_dl_vld[0] <= w_accept;
               for (int i = 1; i < latency - 1; i++) begin
                  r_dl_vld[i] <= r_dl_vld[i-1];
               end
            end
         end

         // Word indices travel alongside their valid bits; no reset needed.
         always_ff @(posedge clock) begin
            r_dl_idx[0] <= w_acc_idx;
            for (int i = 1; i < latency - 1; i++) begin
               r_dl_idx[i] <= r_dl_idx[i-1];
            end
         end

         assign w_push     = r_dl_vld[latency-2];
         assign w_push_idx = r_dl_idx[latency-2];
      end
   endgenerate

   // Response FIFO pointers and occupancy.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + OUT_W'(1);
            2'b01:   r_count <= r_count - OUT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // FIFO storage captures the RAM word as it stood before any same-edge preload write.
   always_ff @(posedge clock) begin
      if (w_push) r_fifo[r_wr_ptr] <= r_mem[w_push_idx];
   end

   // Instruction RAM preload; contents survive reset.
   always_ff @(posedge clock) begin
      if (mem_wr_en) r_mem[w_wr_idx] <= mem_wr_data;
   end

   // Credits cover delay line plus FIFO, so a push can never meet a full FIFO.
   a_no_fifo_overflow: assert property (@(posedge clock) disable iff (reset) !(w_push && w_fifo_full));

endmodule

// File: tb/tb_ir_bus_responder.sv
// Randomized bench for ir_bus_responder with a queue-based reference model.
module tb_ir_bus_responder;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int MW  = 256;
   localparam int LAT = 2;
   localparam int MO  = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          bus_ir_addr_valid;
   logic          bus_ir_addr_ready;
   logic [AW-1:0] bus_ir_addr;
   logic          bus_ir_data_valid;
   logic          bus_ir_data_ready;
   logic [DW-1:0] bus_ir_data;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;

   ir_bus_responder #(
      .data_width(DW), .addr_width(AW), .mem_words(MW),
      .latency(LAT), .max_outstanding(MO)
   ) dut (
      .clock(clock), .reset(reset),
      .bus_ir_addr_valid(bus_ir_addr_valid), .bus_ir_addr_ready(bus_ir_addr_ready),
      .bus_ir_addr(bus_ir_addr),
      .bus_ir_data_valid(bus_ir_data_valid), .bus_ir_data_ready(bus_ir_data_ready),
      .bus_ir_data(bus_ir_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
   );

   always #5 clock = ~clock;

   typedef struct {
      int idx;
      int push_cyc;
   } pend_t;

   int            n_vec = 0;
   int            n_err = 0;
   int            cyc   = 0;
   logic [DW-1:0] m_mem [MW];
   pend_t         pend_q[$];
   logic [DW-1:0] exp_q[$];

   task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc, act, exp);
      end
   endtask

   // One clock: drive inputs, check outputs against the model, then advance the model.
   task automatic cycle(input logic av, input logic [AW-1:0] a, input logic dr,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      bit m_vld, m_rdy, acc, pop;
      @(negedge clock);
      bus_ir_addr_valid = av;
      bus_ir_addr       = a;
      bus_ir_data_ready = dr;
      mem_wr_en         = we;
      mem_wr_addr       = wa;
      mem_wr_data       = wd;
      #1;
      m_vld = (exp_q.size() > 0);
      m_rdy = ((pend_q.size() + exp_q.size()) < MO);
      chk("data_valid", {31'b0, bus_ir_data_valid}, {31'b0, m_vld});
      chk("addr_ready", {31'b0, bus_ir_addr_ready}, {31'b0, m_rdy});
      if (m_vld) chk("data", bus_ir_data, exp_q[0]);
      acc = av && m_rdy;
      pop = m_vld && dr;
      @(posedge clock);
      if (pop) void'(exp_q.pop_front());
      if (acc) pend_q.push_back('{int'((a >> 2) % MW), cyc + LAT - 1});
      while (pend_q.size() > 0 && pend_q[0].push_cyc == cyc) begin
         exp_q.push_back(m_mem[pend_q[0].idx]);
         void'(pend_q.pop_front());
      end
      if (we) m_mem[int'((wa >> 2) % MW)] = wd;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      bus_ir_addr_valid = 1'b0;
      mem_wr_en         = 1'b0;
      reset             = 1'b1;
      #1;
      chk("rst_data_valid", {31'b0, bus_ir_data_valid}, 32'd0);
      chk("rst_addr_ready", {31'b0, bus_ir_addr_ready}, 32'd1);
      pend_q.delete();
      exp_q.delete();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] a;
      logic [AW-1:0] wa;
      reset             = 1'b1;
      bus_ir_addr_valid = 1'b0;
      bus_ir_addr       = '0;
      bus_ir_data_ready = 1'b0;
      mem_wr_en         = 1'b0;
      mem_wr_addr       = '0;
      mem_wr_data       = '0;
      #1;
      chk("init_data_valid", {31'b0, bus_ir_data_valid}, 32'd0);
      chk("init_addr_ready", {31'b0, bus_ir_addr_ready}, 32'd1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < MW; i++) cycle(1'b0, '0, 1'b1, 1'b1, AW'(i * 4), $urandom);
      cycle(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b1, AW'(i * 4), 32'hA0 + DW'(i));

      // single fetch at nominal latency
      cycle(1'b1, 32'h40, 1'b1, 1'b0, '0, '0);
      idle(4);

      // back-to-back streaming
      for (int i = 0; i < 4; i++) cycle(1'b1, AW'(i * 4), 1'b1, 1'b0, '0, '0);
      idle(5);

      // backpressure fills the credits
      for (int i = 0; i < 6; i++) cycle(1'b1, AW'(i * 4), 1'b0, 1'b0, '0, '0);
      idle(8);

      // aliasing: low bits and bits above the RAM depth ignored
      cycle(1'b1, 32'h403, 1'b1, 1'b0, '0, '0);
      idle(4);

      // same-edge write at FIFO push is not seen; the next request is
      cycle(1'b1, 32'h14, 1'b1, 1'b0, '0, '0);
      cycle(1'b0, '0, 1'b1, 1'b1, 32'h14, 32'h1234);
      idle(3);
      cycle(1'b1, 32'h14, 1'b1, 1'b0, '0, '0);
      idle(4);

      // reset with requests in flight
      for (int i = 0; i < 3; i++) cycle(1'b1, AW'(i * 4), 1'b0, 1'b0, '0, '0);
      do_reset();
      idle(4);
      cycle(1'b1, 32'h40, 1'b1, 1'b0, '0, '0);
      idle(4);

      // random traffic with colliding preload writes and occasional reset
      for (int n = 0; n < 3000; n++) begin
         a  = ($urandom_range(0, 3) == 0) ? $urandom : AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
         wa = AW'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 499) == 0) do_reset();
         cycle($urandom_range(0, 99) < 70, a, $urandom_range(0, 99) < 60,
               $urandom_range(0, 3) == 0, wa, $urandom);
      end
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
